// File: rtl/shifter_seq.sv
// rtl/shifter_seq.sv - multi-cycle shift engine, up to 3 bit positions per clock
module shifter_seq #(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SW-1:0]    shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;

  logic [1:0]       step_k;
  logic [WIDTH-1:0] sh1, sh2, sh3, stepped;
  logic             fill;

  // Each bit picks from data shifted by 0..3 positions; the mode chooses the fill.
  always_comb begin
    fill = (mode_q == OP_ASR) ? data_q[WIDTH-1] : 1'b0;
    sh1  = data_q;
    sh2  = data_q;
    sh3  = data_q;
    case (mode_q)
      OP_LSL: begin
        sh1 = {data_q[WIDTH-2:0], 1'b0};
        sh2 = {data_q[WIDTH-3:0], 2'b00};
        sh3 = {data_q[WIDTH-4:0], 3'b000};
      end
      OP_LSR, OP_ASR: begin
        sh1 = {fill, data_q[WIDTH-1:1]};
        sh2 = {{2{fill}}, data_q[WIDTH-1:2]};
        sh3 = {{3{fill}}, data_q[WIDTH-1:3]};
      end
      default: begin
        sh1 = {data_q[0], data_q[WIDTH-1:1]};
        sh2 = {data_q[1:0], data_q[WIDTH-1:2]};
        sh3 = {data_q[2:0], data_q[WIDTH-1:3]};
      end
    endcase
  end

  always_comb begin
    step_k = (rem_q >= SW'(3)) ? 2'd3 : rem_q[1:0];
    case (step_k)
      2'd1:    stepped = sh1;
      2'd2:    stepped = sh2;
      2'd3:    stepped = sh3;
      default: stepped = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          data_d  = d_in;
          mode_d  = op;
          rem_d   = shamt;
          state_d = (shamt != '0) ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d = stepped;
        rem_d  = rem_q - SW'(step_k);
        if (rem_d == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  assign d_out = data_q;
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);

endmodule
